// File: rtl/par_ser_converter_32.sv
// FIFO-fed parallel-to-serial converter: LSB first, zero-gap back-to-back frames via a one-word prefetch.
// Optional macro PS_PARITY_EN appends an even-parity bit to every frame.
module par_ser_converter_32 #(
  parameter int WORD_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  empty,
  input  logic                  En,
  output logic                  read,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic                  word_done,
  output logic                  busy
);

`ifdef PS_PARITY_EN
  localparam int FRAME_LEN = WORD_WIDTH + 1;
`else
  localparam int FRAME_LEN = WORD_WIDTH;
`endif
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_PREF = CNT_WIDTH'(FRAME_LEN - 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // S_IDLE: waiting for En & !empty | S_WAIT: FIFO read data in flight | S_SHIFT: frame bits on serial_out
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT} state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_pending;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [FRAME_LEN-1:0]   w_load;
  logic                   w_last;
  logic                   w_pref;
  logic                   w_load_en;

`ifdef PS_PARITY_EN
  assign w_load = {^data_in, data_in};
`else
  assign w_load = data_in;
`endif

  assign w_last    = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
  assign w_pref    = (r_state == S_SHIFT) && (r_cnt == CNT_PREF) && !r_pending;
  assign w_load_en = (r_state == S_WAIT) || (w_last && r_pending);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (read) w_next = S_WAIT;
      S_WAIT:  w_next = S_SHIFT;
      S_SHIFT: if (w_last && !r_pending) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    read         = 1'b0;
    if (!rst && En && !empty)
      read = (r_state == S_IDLE) || w_pref;
    serial_valid = (r_state == S_SHIFT);
    serial_out   = serial_valid & r_shift[0];
    frame_start  = serial_valid && (r_cnt == '0);
    word_done    = w_last;
    busy         = (r_state != S_IDLE);
  end

  // Once the prefetch read is issued the word is committed, even if empty or En change afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_shift   <= '0;
    end else if (w_load_en) begin
      r_shift   <= w_load;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_ONE;
      if (w_pref && read) r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_par_ser_converter_32.sv
// Randomised bench for par_ser_converter_32 against a frame-schedule model; honours PS_PARITY_EN.
module tb_par_ser_converter_32;
  localparam int WW = 32;
`ifdef PS_PARITY_EN
  localparam int FL = WW + 1;
`else
  localparam int FL = WW;
`endif

  typedef struct {
    int          start;
    logic [WW:0] bits;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          empty = 1'b1;
  logic          En = 1'b0;
  logic [WW-1:0] data_in = '0;
  logic          read, serial_out, serial_valid, frame_start, word_done, busy;

  logic          n_en = 1'b0;
  logic          n_rst = 1'b1;
  logic          rd_seen = 1'b0;
  int            t = 0;
  int            last_rd = -100;
  int            g_idx = -1;
  int            n_total = 0;
  int            n_bad = 0;
  logic [WW-1:0] fifo_q[$];
  frame_t        frames[$];

  always #5 clk = ~clk;

  par_ser_converter_32 #(.WORD_WIDTH(WW), .CNT_WIDTH(6)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .empty(empty), .En(En),
    .read(read), .serial_out(serial_out), .serial_valid(serial_valid),
    .frame_start(frame_start), .word_done(word_done), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // One clock cycle: inputs change just after the rising edge, outputs are checked at the falling edge.
  task automatic step();
    logic   e_valid, e_out, e_fs, e_wd, e_busy, e_read;
    int     idx, last_end;
    frame_t f;
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) data_in = fifo_q.pop_front();
    else                              data_in = $urandom();
    En    = n_en;
    rst   = n_rst;
    empty = (fifo_q.size() == 0);
    t++;
    @(negedge clk);
    while (frames.size() > 0 && frames[0].start + FL - 1 < t) void'(frames.pop_front());
    if (rst) begin
      frames.delete();
      last_rd = -100;
    end
    e_valid = 1'b0; e_out = 1'b0; e_fs = 1'b0; e_wd = 1'b0; g_idx = -1;
    if (frames.size() > 0 && frames[0].start <= t) begin
      idx     = t - frames[0].start;
      g_idx   = idx;
      e_valid = 1'b1;
      e_out   = frames[0].bits[idx];
      e_fs    = (idx == 0);
      e_wd    = (idx == FL - 1);
    end
    e_busy   = e_valid || (t == last_rd + 1);
    last_end = (frames.size() > 0) ? frames[frames.size()-1].start + FL - 1 : -100;
    e_read   = !rst && En && !empty && (t > last_end || t == last_end - 1);
    check_val("read",         {31'b0, read},         {31'b0, e_read});
    check_val("serial_valid", {31'b0, serial_valid}, {31'b0, e_valid});
    check_val("serial_out",   {31'b0, serial_out},   {31'b0, e_out});
    check_val("frame_start",  {31'b0, frame_start},  {31'b0, e_fs});
    check_val("word_done",    {31'b0, word_done},    {31'b0, e_wd});
    check_val("busy",         {31'b0, busy},         {31'b0, e_busy});
    if (e_read) begin
      f.start = t + 2;
`ifdef PS_PARITY_EN
      f.bits  = {^fifo_q[0], fifo_q[0]};
`else
      f.bits  = {1'b0, fifo_q[0]};
`endif
      frames.push_back(f);
      last_rd = t;
    end
    rd_seen = read;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_idx(input int target);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      step();
      if (g_idx == target) found = 1'b1;
    end
    check_val("reach_idx", {31'b0, found}, 32'd1);
  endtask

  initial begin
    // Word waiting and En high during reset: no read may escape until rst falls.
    fifo_q.push_back(32'hFFFF_AAAA);
    n_en = 1'b1;
    run(3);
    n_rst = 1'b0;
    run(45);

    fifo_q.push_back(32'h0000_0001);
    fifo_q.push_back(32'h8000_0000);
    run(80);

    fifo_q.push_back($urandom());
    run(45);

    fifo_q.push_back($urandom());
    fifo_q.push_back($urandom());
    wait_idx(9);
    n_en = 1'b0;
    run(80);
    n_en = 1'b1;
    run(80);

    fifo_q.push_back($urandom());
    fifo_q.push_back($urandom());
    wait_idx(9);
    n_rst = 1'b1;
    run(2);
    n_rst = 1'b0;
    run(90);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3 && fifo_q.size() < 4) fifo_q.push_back($urandom());
      n_en  = ($urandom_range(0, 9) != 0);
      n_rst = ($urandom_range(0, 299) == 0);
      step();
    end
    n_rst = 1'b0;
    run(80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/par_ser_converter_32.md
PAR_SER_CONVERTER_32 -- requirements
Module: par_ser_converter_32

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, parallel word width.
REQ-002 SHALL have parameter CNT_WIDTH, default 6, bit-index counter width; must hold FRAME_LEN-1.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port data_in, input, WORD_WIDTH, FIFO registered read data; valid the cycle after read is sampled.
REQ-006 SHALL have port empty, input, 1, FIFO empty flag.
REQ-007 SHALL have port En, input, 1, transmit enable.
REQ-008 SHALL have port read, output, 1, FIFO pop request, combinational, at most one cycle per word.
REQ-009 SHALL have port serial_out, output, 1, serial data bit, LSB first.
REQ-010 SHALL have port serial_valid, output, 1, high while serial_out carries a frame bit.
REQ-011 SHALL have port frame_start, output, 1, pulse on bit index 0 of each frame.
REQ-012 SHALL have port word_done, output, 1, pulse on the last bit index of each frame.
REQ-013 SHALL have port busy, output, 1, high in any state other than S_IDLE.

Function
REQ-014 SHALL define FRAME_LEN as WORD_WIDTH, or WORD_WIDTH+1 per REQ-031.
REQ-015 SHALL implement states S_IDLE, S_WAIT and S_SHIFT.
REQ-016 In S_IDLE with En=1 and empty=0, the block SHALL assert read that cycle and move to S_WAIT.
REQ-017 In S_WAIT, the block SHALL load the shift register from data_in at the cycle end, clear cnt and move to S_SHIFT.
REQ-018 In S_SHIFT, the block SHALL drive serial_out from shift register bit 0, hold serial_valid=1, shift right one bit per cycle and increment cnt.
REQ-019 At cnt==FRAME_LEN-2 with En=1 and empty=0, the block SHALL assert read for one cycle (prefetch) and set a pending flag.
REQ-020 At cnt==FRAME_LEN-1 with pending set, the block SHALL load data_in, clear cnt and pending, and stay in S_SHIFT, giving zero gap between frames.
REQ-021 At cnt==FRAME_LEN-1 with pending clear, the block SHALL go to S_IDLE.
REQ-022 Latency: read in cycle T SHALL give the first bit in cycle T+2; an idle-started frame therefore has a minimum gap of 2 cycles.
REQ-023 En falling mid-frame SHALL let the current frame complete; no new read is issued after that.
REQ-024 empty rising after a prefetch SHALL have no effect, because the word is already committed.
REQ-025 read SHALL never be asserted while empty=1, while rst=1, or in S_WAIT.
REQ-026 When serial_valid=0, serial_out SHALL be 0.
REQ-027 cnt SHALL never exceed FRAME_LEN-1 and SHALL not wrap in S_IDLE.

Reset
REQ-028 While rst=1, the block SHALL hold state=S_IDLE, cnt=0, pending=0, shift register=0, with read, serial_out, serial_valid, frame_start, word_done and busy all 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial word at once with no further bits; a prefetched word is lost.
REQ-030 After rst falls, the first read SHALL occur no earlier than the first rising edge at which En=1 and empty=0.

Configuration
REQ-031 With macro PS_PARITY_EN defined, FRAME_LEN SHALL be WORD_WIDTH+1, and bit index WORD_WIDTH SHALL carry the even-parity bit (XOR of the loaded word, computed at load).
REQ-032 Without PS_PARITY_EN, FRAME_LEN SHALL be WORD_WIDTH, no parity logic SHALL exist, and word_done SHALL fall on index WORD_WIDTH-1.

Verification
REQ-033 Single word, empty=0 for one word, data_in=32'hFFFF_AAAA, En=1 at cycle T -> read=1 in T only; serial_valid in T+2..T+33; bits 0,1,0,1... for 16 cycles then 1 for 16; frame_start in T+2; word_done in T+33; then S_IDLE.
REQ-034 Back-to-back, FIFO holding 32'h0000_0001 then 32'h8000_0000 -> second read at bit index 30; serial_valid high for 64 consecutive cycles; bit 0 = 1, bit 63 = 1, all other bits 0.
REQ-035 FIFO going empty before index 30 -> no prefetch; serial_valid drops after index 31; busy=0 one cycle later.
REQ-036 En=0 at bit index 10 -> frame completes all 32 bits, then no further read while En=0.
REQ-037 rst pulse at bit index 10 -> serial_valid, serial_out and busy are 0 immediately; next frame needs a fresh read.
REQ-038 With PS_PARITY_EN, data 32'h0000_0007 -> 33-bit frame; index 32 = 1; word_done on index 32; prefetch at index 31.
